// File: rtl/imm_encoder_pkg.sv
// Shared definitions for the immediate encoder: widths, ImmSel encodings,
// field bit positions and the representability check for each format.
package imm_encoder_pkg;

  localparam int unsigned WIDTH_INST_LENGTH = 32;
  localparam int unsigned WIDTH_SEL_LENGTH  = 3;
  localparam int unsigned WIDTH_DATA_LENGTH = 32;
  localparam int unsigned WIDTH_CNT_LENGTH  = 16;

  typedef enum logic [WIDTH_SEL_LENGTH-1:0] {
    IMM_I     = 3'b000,
    IMM_S     = 3'b001,
    IMM_B     = 3'b010,
    IMM_U     = 3'b011,
    IMM_J     = 3'b100,
    IMM_SHAMT = 3'b101,
    IMM_ZIMM  = 3'b110,
    IMM_RSVD  = 3'b111
  } immSelT;

  // Low bit of each immediate-bearing field inside the instruction word
  localparam int unsigned I_LSB     = 20;
  localparam int unsigned S_HI_LSB  = 25;
  localparam int unsigned S_LO_LSB  = 7;
  localparam int unsigned U_LSB     = 12;
  localparam int unsigned SHAMT_LSB = 20;
  localparam int unsigned ZIMM_LSB  = 15;

  // 1 when the selected format cannot hold imm (range, alignment, or reserved select)
  function automatic logic immRangeErr(input immSelT sel,
                                       input logic [WIDTH_DATA_LENGTH-1:0] imm);
    case (sel)
      IMM_I, IMM_S:        return !((&imm[31:11]) || !(|imm[31:11]));
      IMM_B:               return !((&imm[31:12]) || !(|imm[31:12])) || imm[0];
      IMM_U:               return |imm[11:0];
      IMM_J:               return !((&imm[31:20]) || !(|imm[31:20])) || imm[0];
      IMM_SHAMT, IMM_ZIMM: return |imm[31:5];
      default:             return 1'b1;
    endcase
  endfunction

endpackage

// File: rtl/imm_encoder_pack.sv
// imm_pack: combinational packer. Replaces the immediate fields of the
// template Inst selected by ImmSel with bits of Imm.
//  Inst    in  32  template instruction
//  ImmSel  in  3   format select
//  Imm     in  32  immediate value
//  InstOut out 32  packed instruction (template unchanged when Err)
//  Err     out 1   immediate not representable / reserved select
module imm_pack
  import imm_encoder_pkg::*;
(
  input  logic [WIDTH_INST_LENGTH-1:0] Inst,
  input  logic [WIDTH_SEL_LENGTH-1:0]  ImmSel,
  input  logic [WIDTH_DATA_LENGTH-1:0] Imm,
  output logic [WIDTH_INST_LENGTH-1:0] InstOut,
  output logic                         Err
);

  logic [WIDTH_INST_LENGTH-1:0] packedInst;

  // Field replacement per format; all other template bits pass through
  always_comb begin
    packedInst = Inst;
    Err        = immRangeErr(immSelT'(ImmSel), Imm);
    case (immSelT'(ImmSel))
      IMM_I: packedInst[I_LSB +: 12] = Imm[11:0];
      IMM_S: begin
        packedInst[S_HI_LSB +: 7] = Imm[11:5];
        packedInst[S_LO_LSB +: 5] = Imm[4:0];
      end
      IMM_B: begin
        packedInst[31]    = Imm[12];
        packedInst[30:25] = Imm[10:5];
        packedInst[11:8]  = Imm[4:1];
        packedInst[7]     = Imm[11];
      end
      IMM_U: packedInst[U_LSB +: 20] = Imm[31:12];
      IMM_J: begin
        packedInst[31]    = Imm[20];
        packedInst[30:21] = Imm[10:1];
        packedInst[20]    = Imm[11];
        packedInst[19:12] = Imm[19:12];
      end
      IMM_SHAMT: packedInst[SHAMT_LSB +: 5] = Imm[4:0];
      IMM_ZIMM:  packedInst[ZIMM_LSB +: 5]  = Imm[4:0];
      default: ;
    endcase
    InstOut = Err ? Inst : packedInst;
  end

endmodule

// File: rtl/imm_encoder.sv
// imm_encoder: 2-stage valid/ready pipeline that merges an immediate into a
// template RV32I instruction and flags unrepresentable immediates.
//  clk, rst  clock / async active-high reset
//  InValid, InReady, InstIn, ImmSel, DataIn   input beat
//  OutValid, OutReady, InstOut, Err           output beat
//  EncCount, ErrCount  saturating delivered-beat counters (good / error)
module imm_encoder
  import imm_encoder_pkg::*;
(
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         InValid,
  output logic                         InReady,
  input  logic [WIDTH_INST_LENGTH-1:0] InstIn,
  input  logic [WIDTH_SEL_LENGTH-1:0]  ImmSel,
  input  logic [WIDTH_DATA_LENGTH-1:0] DataIn,
  output logic                         OutValid,
  input  logic                         OutReady,
  output logic [WIDTH_INST_LENGTH-1:0] InstOut,
  output logic                         Err,
  output logic [WIDTH_CNT_LENGTH-1:0]  EncCount,
  output logic [WIDTH_CNT_LENGTH-1:0]  ErrCount
);

  logic                         s1Valid;
  logic [WIDTH_INST_LENGTH-1:0] s1Inst;
  logic [WIDTH_SEL_LENGTH-1:0]  s1Sel;
  logic [WIDTH_DATA_LENGTH-1:0] s1Data;
  logic                         s1RangeErr;
  logic                         s1Adv;
  logic                         deliver;
  logic [WIDTH_INST_LENGTH-1:0] packInst;
  logic                         packErr;

  // OutValid is the S2 valid flag
  assign s1Adv   = !OutValid || OutReady;
  assign InReady = !s1Valid || s1Adv;
  assign deliver = OutValid && OutReady;

  // S1: capture beat and its range/alignment check
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1Valid    <= 1'b0;
      s1Inst     <= '0;
      s1Sel      <= '0;
      s1Data     <= '0;
      s1RangeErr <= 1'b0;
    end else if (InReady) begin
      s1Valid <= InValid;
      if (InValid) begin
        s1Inst     <= InstIn;
        s1Sel      <= ImmSel;
        s1Data     <= DataIn;
        s1RangeErr <= immRangeErr(immSelT'(ImmSel), DataIn);
      end
    end
  end

  imm_pack uPack (
    .Inst    (s1Inst),
    .ImmSel  (s1Sel),
    .Imm     (s1Data),
    .InstOut (packInst),
    .Err     (packErr)
  );

  // S2: output register, held while stalled
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      OutValid <= 1'b0;
      InstOut  <= '0;
      Err      <= 1'b0;
    end else if (s1Adv) begin
      OutValid <= s1Valid;
      if (s1Valid) begin
        InstOut <= packInst;
        Err     <= s1RangeErr || packErr;
      end
    end
  end

  // Delivered-beat statistics, saturating
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      EncCount <= '0;
      ErrCount <= '0;
    end else if (deliver) begin
      if (!Err && (EncCount != '1)) EncCount <= EncCount + WIDTH_CNT_LENGTH'(1);
      if (Err && (ErrCount != '1))  ErrCount <= ErrCount + WIDTH_CNT_LENGTH'(1);
    end
  end

endmodule

// File: tb/tb_imm_encoder.sv
module tb_imm_encoder;

  logic        clk = 1'b0;
  logic        rst;
  logic        InValid;
  logic        InReady;
  logic [31:0] InstIn;
  logic [2:0]  ImmSel;
  logic [31:0] DataIn;
  logic        OutValid;
  logic        OutReady;
  logic [31:0] InstOut;
  logic        Err;
  logic [15:0] EncCount;
  logic [15:0] ErrCount;

  typedef struct {
    logic [31:0] inst;
    logic        err;
    logic        rt;
    logic [2:0]  sel;
    logic [31:0] data;
  } expT;

  expT sb[$];
  int nAssert = 0;
  int nFail   = 0;
  int expEnc  = 0;
  int expErr  = 0;
  logic        holdPending = 1'b0;
  logic [31:0] holdInst;
  logic        holdErr;
  logic        sawInReadyLow = 1'b0;

  imm_encoder dut (
    .clk      (clk),
    .rst      (rst),
    .InValid  (InValid),
    .InReady  (InReady),
    .InstIn   (InstIn),
    .ImmSel   (ImmSel),
    .DataIn   (DataIn),
    .OutValid (OutValid),
    .OutReady (OutReady),
    .InstOut  (InstOut),
    .Err      (Err),
    .EncCount (EncCount),
    .ErrCount (ErrCount)
  );

  always #5 clk = ~clk;

  function automatic void chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    nAssert++;
    if (act !== exp) begin
      nFail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endfunction

  // Reference immediate generator (decode direction)
  function automatic logic [31:0] immGen(input logic [31:0] i, input logic [2:0] sel);
    case (sel)
      3'b000:  return {{20{i[31]}}, i[31:20]};
      3'b001:  return {{20{i[31]}}, i[31:25], i[11:7]};
      3'b010:  return {{19{i[31]}}, i[31], i[7], i[30:25], i[11:8], 1'b0};
      3'b011:  return {i[31:12], 12'b0};
      3'b100:  return {{11{i[31]}}, i[31], i[19:12], i[20], i[30:21], 1'b0};
      3'b101:  return {27'b0, i[24:20]};
      3'b110:  return {27'b0, i[19:15]};
      default: return 32'hDEAD_BEEF;
    endcase
  endfunction

  // Monitor / scoreboard
  always @(negedge clk) begin
    expT e;
    if (rst) begin
      holdPending = 1'b0;
    end else begin
      if (holdPending) begin
        chk("hold_valid", 32'(OutValid), 32'd1);
        chk("hold_inst", InstOut, holdInst);
        chk("hold_err", 32'(Err), 32'(holdErr));
      end
      if (OutValid && OutReady) begin
        if (sb.size() == 0) begin
          chk("unexpected_beat", 32'd1, 32'd0);
        end else begin
          e = sb.pop_front();
          chk("out_err", 32'(Err), 32'(e.err));
          if (e.rt) chk("roundtrip", immGen(InstOut, e.sel), e.data);
          else      chk("out_inst", InstOut, e.inst);
          if (e.err) expErr++; else expEnc++;
        end
      end
      holdPending = OutValid && !OutReady;
      holdInst    = InstOut;
      holdErr     = Err;
      if (!InReady) sawInReadyLow = 1'b1;
    end
  end

  task automatic send(input logic [31:0] inst, input logic [2:0] sel,
                      input logic [31:0] data, input expT e);
    bit acc = 0;
    int n = 0;
    InstIn = inst; ImmSel = sel; DataIn = data; InValid = 1'b1;
    sb.push_back(e);
    while (!acc) begin
      @(negedge clk);
      acc = InReady;
      @(posedge clk); #1;
      n++;
      if (!acc && n > 100) begin
        chk("accept_timeout", 32'd1, 32'd0);
        break;
      end
    end
    InValid = 1'b0;
  endtask

  task automatic sendChk(input logic [31:0] inst, input logic [2:0] sel,
                         input logic [31:0] data, input logic [31:0] expInst, input logic expE);
    expT e;
    e.inst = expInst; e.err = expE; e.rt = 1'b0; e.sel = sel; e.data = data;
    send(inst, sel, data, e);
  endtask

  task automatic drain();
    int n = 0;
    while (sb.size() != 0 && n < 200) begin
      @(posedge clk); n++;
    end
    if (sb.size() != 0) chk("drain_timeout", 32'(sb.size()), 32'd0);
    repeat (2) @(posedge clk);
    #1;
  endtask

  task automatic doReset();
    @(posedge clk); #1;
    rst = 1'b1;
    sb.delete();
    expEnc = 0; expErr = 0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end

  initial begin
    logic [31:0] r, d, t;
    logic [2:0]  s;
    rst = 1'b1; InValid = 1'b0; InstIn = '0; ImmSel = '0; DataIn = '0; OutReady = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_outvalid", 32'(OutValid), 32'd0);
    chk("rst_instout", InstOut, 32'd0);
    chk("rst_err", 32'(Err), 32'd0);
    chk("rst_enccount", 32'(EncCount), 32'd0);
    chk("rst_errcount", 32'(ErrCount), 32'd0);
    rst = 1'b0;
    @(posedge clk); #1;
    chk("rst_inready", 32'(InReady), 32'd1);

    // 1: I max, with latency
    sendChk(32'h0000_0013, 3'b000, 32'h0000_07FF, 32'h7FF0_0013, 1'b0);
    @(negedge clk); chk("lat_cycle1", 32'(OutValid), 32'd0);
    @(negedge clk); chk("lat_cycle2", 32'(OutValid), 32'd1);
    drain();
    // 2: I overflow
    sendChk(32'h0000_0013, 3'b000, 32'h0000_0800, 32'h0000_0013, 1'b1);
    drain();
    chk("errcount_t2", 32'(ErrCount), 32'd1);
    chk("enccount_t2", 32'(EncCount), 32'd1);
    // 3: U / J / B misalign and other boundaries
    sendChk(32'h0000_0037, 3'b011, 32'hF0F0_0000, 32'hF0F0_0037, 1'b0);
    sendChk(32'h0000_006F, 3'b100, 32'hFFFF_FFFE, 32'hFFFF_F06F, 1'b0);
    sendChk(32'h0000_0063, 3'b010, 32'h0000_0003, 32'h0000_0063, 1'b1);
    sendChk(32'h0000_0013, 3'b000, 32'hFFFF_F7FF, 32'h0000_0013, 1'b1);
    sendChk(32'h0000_006F, 3'b100, 32'h000F_FFFE, 32'h7FFF_F06F, 1'b0);
    sendChk(32'h0000_006F, 3'b100, 32'h0010_0000, 32'h0000_006F, 1'b1);
    sendChk(32'h0000_0037, 3'b011, 32'h0000_1001, 32'h0000_0037, 1'b1);
    sendChk(32'h1234_5678, 3'b111, 32'h0000_0000, 32'h1234_5678, 1'b1);
    sendChk(32'h4000_5013, 3'b101, 32'h0000_0020, 32'h4000_5013, 1'b1);
    drain();
    chk("enccount_t3", 32'(EncCount), 32'(expEnc));
    chk("errcount_t3", 32'(ErrCount), 32'(expErr));

    // 4: backpressure, from a clean reset
    doReset();
    sawInReadyLow = 1'b0;
    fork
      begin
        sendChk(32'h00A0_0093, 3'b000, 32'hFFFF_F800, 32'h8000_0093, 1'b0);
        sendChk(32'h0000_2023, 3'b001, 32'h0000_0123, 32'h1200_21A3, 1'b0);
        sendChk(32'h4000_5013, 3'b101, 32'h0000_001F, 32'h41F0_5013, 1'b0);
        sendChk(32'h3400_5073, 3'b110, 32'h0000_0015, 32'h340A_D073, 1'b0);
        sendChk(32'h0000_0063, 3'b010, 32'hFFFF_FFFC, 32'hFE00_0EE3, 1'b0);
      end
      begin
        repeat (3) @(posedge clk);
        #1 OutReady = 1'b0;
        repeat (3) @(posedge clk);
        #1 OutReady = 1'b1;
      end
    join
    drain();
    chk("bp_inready_dropped", 32'(sawInReadyLow), 32'd1);
    chk("bp_enccount", 32'(EncCount), 32'd5);
    chk("bp_errcount", 32'(ErrCount), 32'd0);

    // 5: round trip with in-range random immediates
    for (int k = 0; k < 24; k++) begin
      expT e;
      r = $urandom;
      t = $urandom;
      s = 3'($urandom_range(0, 6));
      case (s)
        3'b000, 3'b001: d = {{20{r[11]}}, r[11:0]};
        3'b010:         d = {{19{r[12]}}, r[12:1], 1'b0};
        3'b011:         d = {r[31:12], 12'b0};
        3'b100:         d = {{11{r[20]}}, r[20:1], 1'b0};
        default:        d = {27'b0, r[4:0]};
      endcase
      e.inst = '0; e.err = 1'b0; e.rt = 1'b1; e.sel = s; e.data = d;
      send(t, s, d, e);
    end
    drain();

    // 6: reset with two beats in flight
    OutReady = 1'b0;
    sendChk(32'h0000_0013, 3'b000, 32'h0000_0001, 32'h0010_0013, 1'b0);
    sendChk(32'h0000_0013, 3'b000, 32'h0000_0002, 32'h0020_0013, 1'b0);
    @(posedge clk); #1;
    chk("inflight_valid", 32'(OutValid), 32'd1);
    rst = 1'b1;
    sb.delete();
    expEnc = 0; expErr = 0;
    #1;
    chk("midrst_outvalid", 32'(OutValid), 32'd0);
    chk("midrst_enccount", 32'(EncCount), 32'd0);
    chk("midrst_instout", InstOut, 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    OutReady = 1'b1;
    @(posedge clk); #1;
    chk("postrst_inready", 32'(InReady), 32'd1);
    chk("postrst_outvalid", 32'(OutValid), 32'd0);
    sendChk(32'h0000_0013, 3'b000, 32'h0000_0005, 32'h0050_0013, 1'b0);
    drain();
    chk("postrst_enccount", 32'(EncCount), 32'd1);
    chk("postrst_errcount", 32'(ErrCount), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", nAssert, nFail);
    $finish;
  end

endmodule
